// File: rtl/route_cfg_writer.sv
// route_cfg_writer
//   Drives timed routing updates into a router. A load request captures a full
//   routing table (one source select per output) and an activation mask. Each
//   entry that differs from the shadow copy of what the router already holds
//   (or every entry, when force_all_in was set with the load) is written as a
//   SETUP / PULSE / GAP transaction. The activation mask is applied only
//   after all route writes have landed.
//
// Ports
//   clk_in             in   system clock, posedge
//   rst_in             in   synchronous reset, active-high
//   route_map_in       in   entry k = src for output k, bits [k*W_SEL +: W_SEL]
//   actv_mask_in       in   requested output activation mask
//   force_all_in       in   sampled with load_in: write every entry
//   load_in            in   one-cycle load request (ignored while busy)
//   busy_out           out  high from accepted load through done_out
//   src_select_out     out  source select presented to the router
//   dest_select_out    out  destination select presented to the router
//   update_out         out  router update strobe (router latches on rising edge)
//   output_active_out  out  activation mask presented to the router
//   done_out           out  one-cycle pulse when a load completes
//   err_out            out  sticky: last load held a src >= N_IN
module route_cfg_writer #(
  parameter int W_SEL   = 4,
  parameter int N_IN    = 8,
  parameter int N_OUT   = 8,
  parameter int T_PULSE = 2,
  parameter int T_GAP   = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [W_SEL*N_OUT-1:0] route_map_in,
  input  logic [N_OUT-1:0]       actv_mask_in,
  input  logic                   force_all_in,
  input  logic                   load_in,
  output logic                   busy_out,
  output logic [W_SEL-1:0]       src_select_out,
  output logic [W_SEL-1:0]       dest_select_out,
  output logic                   update_out,
  output logic [N_OUT-1:0]       output_active_out,
  output logic                   done_out,
  output logic                   err_out
);

  localparam int T_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [CW-1:0]    PULSE_LAST = CW'(T_PULSE - 1);
  localparam logic [CW-1:0]    GAP_LAST   = CW'(T_GAP - 1);
  localparam logic [W_SEL-1:0] IDX_LAST   = W_SEL'(N_OUT - 1);
  localparam logic [W_SEL:0]   SRC_LIMIT  = (W_SEL + 1)'(N_IN);

  typedef enum logic [2:0] {IDLE, SCAN, SETUP, PULSE, GAP, DONE} state_t;

  state_t st, nxt;

  logic [W_SEL*N_OUT-1:0] map_q;
  logic [N_OUT-1:0]       mask_q;
  logic                   force_q;
  logic [W_SEL-1:0]       idx, idx_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [W_SEL-1:0]       shadow [N_OUT];

  logic [W_SEL-1:0]       cur_src, cur_shadow;
  logic                   capture, set_err, latch_sel, shadow_we;

  logic [W_SEL-1:0]       src_q, dest_q;
  logic [N_OUT-1:0]       active_q;
  logic                   busy_q, update_q, done_q, err_q;

  // Entry selection by compare loop rather than direct indexing, so the
  // W_SEL-bit index never exceeds the N_OUT-deep shadow array.
  always_comb begin
    cur_src    = '0;
    cur_shadow = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (idx == W_SEL'(i)) begin
        cur_src    = map_q[i*W_SEL +: W_SEL];
        cur_shadow = shadow[i];
      end
    end
  end

  always_comb begin
    nxt       = st;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    set_err   = 1'b0;
    latch_sel = 1'b0;
    shadow_we = 1'b0;
    unique case (st)
      IDLE: begin
        if (load_in) begin
          capture = 1'b1;
          idx_nxt = '0;
          nxt     = SCAN;
        end
      end
      SCAN: begin
        if ({1'b0, cur_src} >= SRC_LIMIT) begin
          set_err = 1'b1;
        end
        if (({1'b0, cur_src} < SRC_LIMIT) && (force_q || (cur_src != cur_shadow))) begin
          latch_sel = 1'b1;
          nxt       = SETUP;
        end else if (idx == IDX_LAST) begin
          nxt = DONE;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      SETUP: begin
        cnt_nxt = '0;
        nxt     = PULSE;
      end
      PULSE: begin
        if (cnt == PULSE_LAST) begin
          cnt_nxt = '0;
          nxt     = GAP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          shadow_we = 1'b1;
          cnt_nxt   = '0;
          if (idx == IDX_LAST) begin
            nxt = DONE;
          end else begin
            idx_nxt = idx + 1'b1;
            nxt     = SCAN;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      st    <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      map_q   <= '0;
      mask_q  <= '0;
      force_q <= 1'b0;
      for (int unsigned i = 0; i < N_OUT; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      st  <= nxt;
      idx <= idx_nxt;
      cnt <= cnt_nxt;
      if (capture) begin
        map_q   <= route_map_in;
        mask_q  <= actv_mask_in;
        force_q <= force_all_in;
      end
      for (int unsigned i = 0; i < N_OUT; i++) begin
        if (shadow_we && (idx == W_SEL'(i))) begin
          shadow[i] <= cur_src;
        end
      end
    end
  end

  // Strobes are registered from the next state so update_out is glitch-free
  // yet still asserts in the same cycle the FSM enters PULSE.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      src_q    <= '0;
      dest_q   <= '0;
      active_q <= '0;
      busy_q   <= 1'b0;
      update_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      busy_q   <= (nxt != IDLE);
      update_q <= (nxt == PULSE);
      done_q   <= (nxt == DONE);
      if (latch_sel) begin
        src_q  <= cur_src;
        dest_q <= idx;
      end
      if (st == DONE) begin
        active_q <= mask_q;
      end
      if (capture) begin
        err_q <= 1'b0;
      end else if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign busy_out          = busy_q;
  assign src_select_out    = src_q;
  assign dest_select_out   = dest_q;
  assign update_out        = update_q;
  assign output_active_out = active_q;
  assign done_out          = done_q;
  assign err_out           = err_q;

endmodule
